mdu_seq: RTL and testbench
==========================

# mdu_seq

Iterative unsigned multiply/divide sequencer that drives the CPU's shared 32-bit ALU instance, one ALU operation per cycle, to produce 64-bit products and 32-bit quotient/remainder into HI/LO. It sits beside the execute stage. While `busy`, the CPU top muxes the ALU operand and control inputs from this block. A 32-cycle shift-add or restoring-division loop reuses the ALU's add (0000) and subtract (1000) functions instead of a dedicated multiplier or divider.

## Interface
Parameters:
- none (iteration count fixed at 32, from package constant `MDU_ITER`)

Ports:
- `clock` in 1: sole clock, rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: request pulse, sampled only in IDLE
- `op` in 1: 0 = MULTU, 1 = DIVU
- `rs` in 32: multiplier / dividend
- `rt` in 32: multiplicand / divisor
- `busy` out 1: high during iteration cycles
- `done` out 1: one-cycle completion pulse
- `hi` out 32: product[63:32] / remainder
- `lo` out 32: product[31:0] / quotient
- `alu_a` out 32: ALU operand a
- `alu_b` out 32: ALU operand b
- `alu_aluc` out 4: ALU function code
- `alu_s` in 32: ALU result, combinational from `alu_a`/`alu_b`/`alu_aluc`

## Operation
- **States and transitions**
  - States: IDLE, RUN. A 5-bit iteration counter `cnt` and a 32-bit operand register `opnd` hold the loop.
  - IDLE & `start`: latch `op`, set `opnd` = `rt`, `hi` = 0, `lo` = `rs`, `cnt` = 0, and go to RUN.
  - RUN: perform one iteration per cycle. On the edge where `cnt` = 31, go to IDLE and set `done` for the next cycle.
- **MULTU iteration**
  - Drive `alu_aluc` = 0000 and `alu_a` = `hi`.
  - Drive `alu_b` = `opnd` if `lo[0]`, else 0.
  - Compute sum = `alu_s` and carry = (`alu_s` < `hi`, unsigned compare done locally).
  - Update `hi` = {carry, sum[31:1]} and `lo` = {sum[0], `lo[31:1]`}.
- **DIVU iteration (restoring)**
  - Compute sh = {`hi[30:0]`, `lo[31]`} and msb = `hi[31]`.
  - Drive `alu_aluc` = 1000, `alu_a` = sh, `alu_b` = `opnd`.
  - Compute ge = msb | (sh >= `opnd`).
  - If ge: `hi` = `alu_s`, `lo` = {`lo[30:0]`, 1}. Otherwise: `hi` = sh, `lo` = {`lo[30:0]`, 0}.
- **Divide by zero**: no special case. The loop naturally yields `lo` = FFFFFFFF and `hi` = `rs`.
- **Idle ALU outputs**: in IDLE, `alu_a` = `alu_b` = 0 and `alu_aluc` = 0000.
- **`hi`/`lo` hold**: values hold from `done` until the next accepted start. Intermediate values are visible during RUN and are not valid results.

## Timing
- **Reset values**: state IDLE, `cnt` = 0, `hi` = `lo` = 0, `busy` = 0, `done` = 0, `opnd` = 0.
- **Latency**
  - Start is accepted at edge E0.
  - `busy` is 1 in the 32 cycles following E0; iterations occur at edges E1..E32.
  - `done` = 1 and `busy` = 0 in the cycle after E32, with `hi`/`lo` final in that cycle.
  - Start-to-done is 33 cycles.
- **Start rules**
  - `start` while `busy` is ignored, with no queuing.
  - `start` in the `done` cycle is accepted, so back-to-back ops are possible.
  - `rs`, `rt` and `op` are sampled only at the accept edge and may change afterwards.
- **Reset mid-RUN**: aborts at the next edge. All registers return to reset values, `done` is not pulsed, and the ALU outputs return to idle values.
- `alu_s` is used in the same cycle it is driven; there are no ALU pipeline registers.

## Structure
- **Package `mdu_pkg`** holds:
  - `ALUC_ADD` = 4'b0000 and `ALUC_SUB` = 4'b1000
  - `MDU_MULTU` = 0 and `MDU_DIVU` = 1
  - `MDU_ITER` = 32
  - state enum {IDLE, RUN}
- **No sub-module**. The step logic is a single combinational block inside `mdu_seq`. The ALU is instantiated in the CPU top, not here.

## Test plan
- MULTU 7 × 6 -> after 33 cycles `done` = 1, `hi` = 0, `lo` = 42; `busy` high exactly 32 cycles.
- MULTU FFFFFFFF × FFFFFFFF -> `hi` = FFFFFFFE, `lo` = 00000001 (exercises carry on every iteration).
- DIVU 100 / 7 -> `lo` = 14, `hi` = 2; DIVU 80000000 / 3 -> `lo` = 2AAAAAAA, `hi` = 2 (exercises msb path).
- DIVU 5 / 0 -> `lo` = FFFFFFFF, `hi` = 5, `done` at 33 cycles.
- `start` pulsed at cycles 5 and 20 of a running MULTU -> ignored, result unchanged. A new start in the `done` cycle -> accepted; second result correct 33 cycles later.
- Reset asserted at iteration 10 of DIVU -> next cycle `busy` = 0, `hi` = `lo` = 0, `alu_aluc` = 0000, no `done` pulse.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared constants and types for the iterative multiply/divide sequencer.
//   ALU function codes used by the loop, op encodings, iteration count,
//   and the sequencer state type.
package mdu_pkg;

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b1000;

    localparam logic MDU_MULTU = 1'b0;
    localparam logic MDU_DIVU  = 1'b1;

    localparam int unsigned MDU_ITER  = 32;
    localparam int unsigned CNT_W     = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_ITER - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/mdu_seq.sv
// Iterative unsigned MULTU/DIVU sequencer driving a shared external 32-bit ALU.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   start, op, rs, rt   : request pulse (IDLE only), 0=MULTU 1=DIVU, operands
//   busy, done          : iteration-in-progress flag, one-cycle completion pulse
//   hi, lo              : product[63:32]/remainder, product[31:0]/quotient
//   alu_a, alu_b, alu_aluc : operands/function code to the shared ALU
//   alu_s               : combinational ALU result for the current drive
module mdu_seq
    import mdu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_aluc,
    input  logic [31:0] alu_s
);

    mdu_state_t       state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [31:0]      opnd_q, opnd_n;
    logic             op_q, op_n;
    logic [31:0]      hi_n, lo_n;
    logic             busy_n, done_n;

    logic [31:0]      sh;
    logic             msb;
    logic             ge;
    logic             carry;

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opnd_q  <= '0;
            op_q    <= MDU_MULTU;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            opnd_q  <= opnd_n;
            op_q    <= op_n;
            hi      <= hi_n;
            lo      <= lo_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    // Next-state, single iteration step and ALU drive.
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        opnd_n   = opnd_q;
        op_n     = op_q;
        hi_n     = hi;
        lo_n     = lo;
        busy_n   = busy;
        done_n   = 1'b0;
        alu_a    = '0;
        alu_b    = '0;
        alu_aluc = ALUC_ADD;
        sh       = {hi[30:0], lo[31]};
        msb      = hi[31];
        ge       = 1'b0;
        carry    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_n    = op;
                    opnd_n  = rt;
                    hi_n    = '0;
                    lo_n    = rs;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    state_n = RUN;
                end
            end

            RUN: begin
                if (op_q == MDU_MULTU) begin
                    // Shift-add: the add overflowed iff the sum wrapped below hi.
                    alu_aluc = ALUC_ADD;
                    alu_a    = hi;
                    alu_b    = lo[0] ? opnd_q : 32'd0;
                    carry    = (alu_s < hi);
                    hi_n     = {carry, alu_s[31:1]};
                    lo_n     = {alu_s[0], lo[31:1]};
                end else begin
                    // Restoring divide: msb covers a 33-bit partial remainder.
                    alu_aluc = ALUC_SUB;
                    alu_a    = sh;
                    alu_b    = opnd_q;
                    ge       = msb | (sh >= opnd_q);
                    hi_n     = ge ? alu_s : sh;
                    lo_n     = {lo[30:0], ge};
                end

                cnt_n = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_n   = '0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed vector table, random ops against
// an arithmetic reference model, ignored starts, back-to-back and reset abort.
module tb_mdu_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_aluc;
    logic [31:0] alu_s;

    int checks   = 0;
    int failures = 0;

    mdu_seq dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .rs       (rs),
        .rt       (rt),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_aluc (alu_aluc),
        .alu_s    (alu_s)
    );

    // Stand-in for the CPU's shared ALU: add and subtract only.
    assign alu_s = (alu_aluc == 4'b1000) ? (alu_a - alu_b) : (alu_a + alu_b);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit product, or quotient/remainder with the
    // divide-by-zero result the loop produces (all-ones, dividend).
    task automatic model(input logic o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] mh, output logic [31:0] ml);
        logic [63:0] p;
        if (o == 1'b0) begin
            p  = {32'd0, a} * {32'd0, b};
            mh = p[63:32];
            ml = p[31:0];
        end else if (b == 32'd0) begin
            mh = a;
            ml = 32'hFFFF_FFFF;
        end else begin
            mh = a % b;
            ml = a / b;
        end
    endtask

    // Present a request now (just after an edge); accept happens at next edge.
    task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        @(posedge clock); #1;
        start = 1'b0;
        op    = 1'($urandom);
        rs    = $urandom;
        rt    = $urandom;
    endtask

    // Called one step after the accept edge; returns inside the done cycle.
    task automatic wait_done(input logic o, input logic [31:0] eh, input logic [31:0] el,
                             input int p1, input int p2, input string nm);
        int lat = 1;
        int bc  = 0;
        chk({nm, " first aluc"}, 64'(alu_aluc), (o == 1'b1) ? 64'h8 : 64'h0);
        while (!done && lat < 40) begin
            if (busy) bc++;
            start = (lat == p1) || (lat == p2);
            if (start) begin
                op = ~o;
                rs = $urandom;
                rt = $urandom;
            end
            @(posedge clock); #1;
            lat++;
        end
        start = 1'b0;
        chk({nm, " latency"}, 64'(lat), 64'd33);
        chk({nm, " busy cycles"}, 64'(bc), 64'd32);
        chk({nm, " done/busy"}, {62'd0, done, busy}, 64'h2);
        chk({nm, " hi"}, 64'(hi), 64'(eh));
        chk({nm, " lo"}, 64'(lo), 64'(el));
        chk({nm, " idle alu"}, {alu_a, alu_b ^ {28'd0, alu_aluc}}, 64'd0);
    endtask

    // Full op followed by a check that done is a single pulse and results hold.
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input int p1, input int p2, input string nm);
        issue(o, a, b);
        wait_done(o, eh, el, p1, p2, nm);
        @(posedge clock); #1;
        chk({nm, " hold"}, {hi, lo}, {eh, el});
        chk({nm, " done pulse"}, {62'd0, done, busy}, 64'd0);
    endtask

    vec_t vecs[5];

    initial begin
        logic [31:0] mh, ml, mh2, ml2;
        logic        ro, ro2;
        logic [31:0] ra, rb, ra2, rb2;
        int          dcount;

        vecs[0] = '{1'b0, 32'd7,          32'd6,          32'd0,          32'd42};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'h0000_0001};
        vecs[2] = '{1'b1, 32'd100,        32'd7,          32'd2,          32'd14};
        vecs[3] = '{1'b1, 32'h8000_0000,  32'd3,          32'd2,          32'h2AAA_AAAA};
        vecs[4] = '{1'b1, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF};

        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        rs    = '0;
        rt    = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset busy/done", {62'd0, busy, done}, 64'd0);
        chk("reset hi/lo", {hi, lo}, 64'd0);
        chk("reset alu", {alu_a, alu_b ^ {28'd0, alu_aluc}}, 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
                   0, 0, $sformatf("vec%0d", i));
        end

        // Starts during RUN must be ignored.
        run_op(1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 5, 20, "ignored start");

        // Random ops against the model.
        for (int i = 0; i < 20; i++) begin
            ro = 1'($urandom);
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            model(ro, ra, rb, mh, ml);
            run_op(ro, ra, rb, mh, ml, 0, 0, $sformatf("rand%0d", i));
        end

        // Back-to-back: second start issued in the done cycle of the first.
        for (int i = 0; i < 3; i++) begin
            ro  = 1'($urandom);
            ra  = $urandom;
            rb  = $urandom >> $urandom_range(0, 31);
            ro2 = ~ro;
            ra2 = $urandom;
            rb2 = $urandom >> $urandom_range(0, 31);
            model(ro, ra, rb, mh, ml);
            model(ro2, ra2, rb2, mh2, ml2);
            issue(ro, ra, rb);
            wait_done(ro, mh, ml, 0, 0, $sformatf("b2b%0d first", i));
            issue(ro2, ra2, rb2);
            wait_done(ro2, mh2, ml2, 0, 0, $sformatf("b2b%0d second", i));
            @(posedge clock); #1;
        end

        // Reset at iteration 10 of a DIVU aborts without a done pulse.
        issue(1'b1, 32'd100, 32'd7);
        repeat (9) @(posedge clock);
        #1;
        chk("pre-abort busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("abort busy/done", {62'd0, busy, done}, 64'd0);
        chk("abort hi/lo", {hi, lo}, 64'd0);
        chk("abort alu", {alu_a, alu_b ^ {28'd0, alu_aluc}}, 64'd0);
        reset = 1'b0;
        dcount = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done || busy) dcount++;
        end
        chk("abort no done", 64'(dcount), 64'd0);

        // Still usable after the abort.
        run_op(1'b1, 32'h8000_0000, 32'd3, 32'd2, 32'h2AAA_AAAA, 0, 0, "post-abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
